// File: rtl/wb_stage_buf.sv
// rtl/wb_stage_buf.sv - write-back stage with a DEPTH-entry commit buffer, load extraction and hazard query
module wb_stage_buf #(
    parameter int DEPTH = 2,
    parameter int AW    = 5,
    parameter int CNT_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [31:0]       in_pc,
    input  logic              in_rf_we,
    input  logic              in_sel_mem,
    input  logic [2:0]        in_ld_mode,
    input  logic [3:0]        in_byte_en,
    input  logic [31:0]       in_mem_rdata,
    input  logic [31:0]       in_alu_result,
    input  logic [AW-1:0]     in_rf_waddr,
    input  logic              rf_ready,
    output logic              rf_we,
    output logic [AW-1:0]     rf_waddr,
    output logic [31:0]       rf_wdata,
    input  logic [AW-1:0]     q_addr0,
    input  logic [AW-1:0]     q_addr1,
    output logic              q_hit0,
    output logic              q_hit1,
    output logic [CNT_W-1:0]  retire_cnt,
    output logic [31:0]       debug_wb_pc,
    output logic [3:0]        debug_wb_rf_wen,
    output logic [4:0]        debug_wb_rf_wnum,
    output logic [31:0]       debug_wb_rf_wdata
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PW:0]   FULL_CNT = DEPTH[PW:0];
    localparam logic [PW:0]   CNT_ONE  = 1;
    localparam logic [PW-1:0] PTR_ONE  = 1;

    typedef struct packed {
        logic [31:0]   pc;
        logic          rf_we;
        logic          sel_mem;
        logic [2:0]    ld_mode;
        logic [3:0]    byte_en;
        logic [31:0]   mem_rdata;
        logic [31:0]   alu_result;
        logic [AW-1:0] waddr;
    } entry_t;

    entry_t           entry_q [DEPTH];
    entry_t           entry_d [DEPTH];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [PW:0]      count_q, count_d;
    logic [CNT_W-1:0] retire_cnt_q, retire_cnt_d;

    entry_t           head;
    entry_t           in_entry;
    logic             head_valid;
    logic             enq;
    logic             commit;
    logic [31:0]      head_data;
    logic [PW-1:0]    slot_off;

    // Reserved load modes fall through to word mode; illegal lane masks yield 0.
    function automatic logic [31:0] load_extract(input entry_t e);
        logic [7:0]  b;
        logic [15:0] h;
        logic        ok;
        logic [31:0] r;
        b  = 8'h00;
        h  = 16'h0000;
        ok = 1'b1;
        r  = e.mem_rdata;
        if (!e.sel_mem) begin
            r = e.alu_result;
        end else if (e.ld_mode[1:0] == 2'b01) begin
            case (e.byte_en)
                4'b0001: b = e.mem_rdata[7:0];
                4'b0010: b = e.mem_rdata[15:8];
                4'b0100: b = e.mem_rdata[23:16];
                4'b1000: b = e.mem_rdata[31:24];
                default: ok = 1'b0;
            endcase
            r = ok ? {{24{b[7] & ~e.ld_mode[2]}}, b} : 32'h0;
        end else if (e.ld_mode[1:0] == 2'b10) begin
            case (e.byte_en)
                4'b0011: h = e.mem_rdata[15:0];
                4'b1100: h = e.mem_rdata[31:16];
                default: ok = 1'b0;
            endcase
            r = ok ? {{16{h[15] & ~e.ld_mode[2]}}, h} : 32'h0;
        end
        return r;
    endfunction

    always_comb begin
        in_entry.pc         = in_pc;
        in_entry.rf_we      = in_rf_we;
        in_entry.sel_mem    = in_sel_mem;
        in_entry.ld_mode    = in_ld_mode;
        in_entry.byte_en    = in_byte_en;
        in_entry.mem_rdata  = in_mem_rdata;
        in_entry.alu_result = in_alu_result;
        in_entry.waddr      = in_rf_waddr;

        head       = entry_q[rd_ptr_q];
        head_valid = (count_q != '0);
        in_ready   = (count_q != FULL_CNT);
        enq        = in_valid & in_ready;
        // Non-writing entries drain regardless of register-file backpressure.
        commit     = head_valid & (rf_ready | ~head.rf_we);
        head_data  = load_extract(head);

        entry_d = entry_q;
        if (enq) begin
            entry_d[wr_ptr_q] = in_entry;
        end
        wr_ptr_d = enq ? wr_ptr_q + PTR_ONE : wr_ptr_q;
        rd_ptr_d = commit ? rd_ptr_q + PTR_ONE : rd_ptr_q;
        case ({enq, commit})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase
        retire_cnt_d = retire_cnt_q + CNT_W'(commit);
    end

    always_comb begin
        rf_we    = head_valid & head.rf_we & (head.waddr != '0) & rf_ready;
        rf_waddr = head_valid ? head.waddr : '0;
        rf_wdata = head_valid ? head_data : 32'h0;

        debug_wb_pc       = head_valid ? head.pc : 32'h0;
        debug_wb_rf_wen   = {4{rf_we}};
        debug_wb_rf_wnum  = 5'(rf_waddr);
        debug_wb_rf_wdata = rf_wdata;
        retire_cnt        = retire_cnt_q;

        // The head stays visible to the query even in the cycle it commits.
        q_hit0   = 1'b0;
        q_hit1   = 1'b0;
        slot_off = '0;
        for (int i = 0; i < DEPTH; i++) begin
            slot_off = PW'(i) - rd_ptr_q;
            if (({1'b0, slot_off} < count_q) && entry_q[i].rf_we && (entry_q[i].waddr != '0)) begin
                if (entry_q[i].waddr == q_addr0) begin
                    q_hit0 = 1'b1;
                end
                if (entry_q[i].waddr == q_addr1) begin
                    q_hit1 = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            retire_cnt_q <= '0;
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            retire_cnt_q <= retire_cnt_d;
        end
    end

    // Payload storage needs no reset: occupancy alone decides what is valid.
    always_ff @(posedge clk) begin
        entry_q <= entry_d;
    end

endmodule

// File: tb/tb_wb_stage_buf.sv
// tb/tb_wb_stage_buf.sv - self-checking bench for wb_stage_buf against a queue-based model
module tb_wb_stage_buf;

    localparam int DEPTH = 2;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_pc;
    logic        in_rf_we;
    logic        in_sel_mem;
    logic [2:0]  in_ld_mode;
    logic [3:0]  in_byte_en;
    logic [31:0] in_mem_rdata;
    logic [31:0] in_alu_result;
    logic [4:0]  in_rf_waddr;
    logic        rf_ready;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic [4:0]  q_addr0, q_addr1;
    logic        q_hit0, q_hit1;
    logic [31:0] retire_cnt;
    logic [31:0] debug_wb_pc;
    logic [3:0]  debug_wb_rf_wen;
    logic [4:0]  debug_wb_rf_wnum;
    logic [31:0] debug_wb_rf_wdata;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    wb_stage_buf #(.DEPTH(DEPTH), .AW(5), .CNT_W(32)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc), .in_rf_we(in_rf_we),
        .in_sel_mem(in_sel_mem), .in_ld_mode(in_ld_mode), .in_byte_en(in_byte_en),
        .in_mem_rdata(in_mem_rdata), .in_alu_result(in_alu_result), .in_rf_waddr(in_rf_waddr),
        .rf_ready(rf_ready), .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
        .q_addr0(q_addr0), .q_addr1(q_addr1), .q_hit0(q_hit0), .q_hit1(q_hit1),
        .retire_cnt(retire_cnt), .debug_wb_pc(debug_wb_pc), .debug_wb_rf_wen(debug_wb_rf_wen),
        .debug_wb_rf_wnum(debug_wb_rf_wnum), .debug_wb_rf_wdata(debug_wb_rf_wdata)
    );

    typedef struct {
        logic [31:0] pc;
        logic        we;
        logic        sel;
        logic [2:0]  mode;
        logic [3:0]  be;
        logic [31:0] rdata;
        logic [31:0] alu;
        logic [4:0]  waddr;
    } ent_t;

    ent_t        mq[$];
    logic [31:0] mret = 32'h0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] model_data(input ent_t e);
        int          nbytes;
        int          first;
        bit          legal;
        logic [3:0]  mask;
        logic [31:0] raw;
        logic [31:0] v;
        if (!e.sel) return e.alu;
        if (e.mode[1:0] == 2'b01) nbytes = 1;
        else if (e.mode[1:0] == 2'b10) nbytes = 2;
        else return e.rdata;
        legal = 0;
        first = 0;
        for (int off = 0; off < 4; off += nbytes) begin
            mask = (nbytes == 1) ? 4'h1 : 4'h3;
            mask = mask << off;
            if (e.be == mask) begin
                legal = 1;
                first = off;
            end
        end
        if (!legal) return 32'h0;
        raw = e.rdata >> (8 * first);
        if (nbytes == 1) begin
            v = raw & 32'hFF;
            if (!e.mode[2] && raw[7]) v = v | 32'hFFFF_FF00;
        end else begin
            v = raw & 32'hFFFF;
            if (!e.mode[2] && raw[15]) v = v | 32'hFFFF_0000;
        end
        return v;
    endfunction

    // Model state advances on each clock edge from the inputs seen at that edge.
    always @(posedge clk or negedge reset) begin
        bit   can_enq;
        bit   do_commit;
        ent_t e;
        if (!reset) begin
            mq.delete();
            mret = 32'h0;
        end else begin
            can_enq   = (mq.size() < DEPTH);
            do_commit = (mq.size() > 0) && (rf_ready || !mq[0].we);
            if (do_commit) begin
                void'(mq.pop_front());
                mret = mret + 32'h1;
            end
            if (in_valid && can_enq) begin
                e.pc = in_pc; e.we = in_rf_we; e.sel = in_sel_mem; e.mode = in_ld_mode;
                e.be = in_byte_en; e.rdata = in_mem_rdata; e.alu = in_alu_result; e.waddr = in_rf_waddr;
                mq.push_back(e);
            end
        end
    end

    always @(negedge clk) begin
        logic        e_ready, e_we, e_hit0, e_hit1;
        logic [4:0]  e_waddr;
        logic [31:0] e_wdata, e_pc;
        e_ready = (mq.size() < DEPTH);
        e_we = 0; e_waddr = 0; e_wdata = 0; e_pc = 0; e_hit0 = 0; e_hit1 = 0;
        if (mq.size() > 0) begin
            e_waddr = mq[0].waddr;
            e_wdata = model_data(mq[0]);
            e_pc    = mq[0].pc;
            e_we    = mq[0].we && (mq[0].waddr != 0) && rf_ready;
        end
        foreach (mq[k]) begin
            if (mq[k].we && mq[k].waddr != 0) begin
                if (mq[k].waddr == q_addr0) e_hit0 = 1;
                if (mq[k].waddr == q_addr1) e_hit1 = 1;
            end
        end
        chk("in_ready", {31'b0, in_ready}, {31'b0, e_ready});
        chk("rf_we", {31'b0, rf_we}, {31'b0, e_we});
        chk("rf_waddr", {27'b0, rf_waddr}, {27'b0, e_waddr});
        chk("rf_wdata", rf_wdata, e_wdata);
        chk("q_hit0", {31'b0, q_hit0}, {31'b0, e_hit0});
        chk("q_hit1", {31'b0, q_hit1}, {31'b0, e_hit1});
        chk("retire_cnt", retire_cnt, mret);
        chk("dbg_pc", debug_wb_pc, e_pc);
        chk("dbg_wen", {28'b0, debug_wb_rf_wen}, {28'b0, {4{e_we}}});
        chk("dbg_wnum", {27'b0, debug_wb_rf_wnum}, {27'b0, e_waddr});
        chk("dbg_wdata", debug_wb_rf_wdata, e_wdata);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [31:0] pc, input logic we, input logic sel, input logic [2:0] mode,
                        input logic [3:0] be, input logic [31:0] rd, input logic [31:0] alu, input logic [4:0] wa);
        bit acc;
        int budget;
        in_pc = pc; in_rf_we = we; in_sel_mem = sel; in_ld_mode = mode; in_byte_en = be;
        in_mem_rdata = rd; in_alu_result = alu; in_rf_waddr = wa; in_valid = 1'b1;
        acc = 0;
        budget = 0;
        while (!acc && budget < 20) begin
            @(negedge clk);
            acc = in_ready;
            step();
            budget++;
        end
        in_valid = 1'b0;
        chk("push_accept", {31'b0, acc}, 32'h1);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #2 reset = 1'b0;
        #2 reset = 1'b1;
        step();
    endtask

    logic [3:0]  be_t  [12] = '{4'b0001, 4'b1100, 4'b0011, 4'b0110, 4'b1000, 4'b0100,
                                4'b0010, 4'b1100, 4'b0110, 4'b1111, 4'b0011, 4'b0101};
    logic [2:0]  md_t  [12] = '{3'b001, 3'b110, 3'b010, 3'b001, 3'b101, 3'b001,
                                3'b101, 3'b010, 3'b000, 3'b011, 3'b000, 3'b110};
    logic        sel_t [12] = '{1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 0, 1};
    logic [31:0] exp_t [12] = '{32'hFFFF_FF85, 32'h0000_80F0, 32'h0000_7F85, 32'h0000_0000,
                                32'h0000_0080, 32'hFFFF_FFF0, 32'h0000_007F, 32'hFFFF_80F0,
                                32'h80F0_7F85, 32'h80F0_7F85, 32'h1234_5678, 32'h0000_0000};

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        time t0, t1;
        reset = 1'b0; rf_ready = 1'b1; q_addr0 = 5'd7; q_addr1 = 5'd0;
        in_valid = 1'b1; in_pc = 32'h100; in_rf_we = 1'b1; in_sel_mem = 1'b0; in_ld_mode = 3'b000;
        in_byte_en = 4'b1111; in_mem_rdata = 32'h0; in_alu_result = 32'h1111; in_rf_waddr = 5'd1;

        repeat (3) @(negedge clk);
        chk("rst_in_ready", {31'b0, in_ready}, 32'h1);
        chk("rst_rf_we", {31'b0, rf_we}, 32'h0);
        chk("rst_retire", retire_cnt, 32'h0);
        step();
        reset = 1'b1;
        @(negedge clk);
        chk("pre_accept_we", {31'b0, rf_we}, 32'h0);
        step();
        in_valid = 1'b0;
        @(negedge clk);
        chk("first_we", {31'b0, rf_we}, 32'h1);
        chk("first_wdata", rf_wdata, 32'h1111);
        chk("first_pc", debug_wb_pc, 32'h100);
        step();
        @(negedge clk);
        chk("first_retire", retire_cnt, 32'h1);
        step();

        rf_ready = 1'b1;
        for (int i = 0; i < 12; i++) begin
            push(32'h200 + 32'(4 * i), 1'b1, sel_t[i], md_t[i], be_t[i], 32'h80F0_7F85, 32'h1234_5678, 5'd3);
            @(negedge clk);
            chk("load", rf_wdata, exp_t[i]);
            step();
        end

        do_reset();
        rf_ready = 1'b0; q_addr0 = 5'd7; q_addr1 = 5'd0;
        push(32'h300, 1'b1, 1'b0, 3'b000, 4'hF, 32'h0, 32'hAAAA_0005, 5'd5);
        push(32'h304, 1'b1, 1'b0, 3'b000, 4'hF, 32'h0, 32'hBBBB_0007, 5'd7);
        @(negedge clk);
        chk("bp_full", {31'b0, in_ready}, 32'h0);
        chk("bp_hit0", {31'b0, q_hit0}, 32'h1);
        chk("bp_hit1", {31'b0, q_hit1}, 32'h0);
        chk("bp_stall_we", {31'b0, rf_we}, 32'h0);
        step();
        in_pc = 32'h308; in_rf_waddr = 5'd9; in_alu_result = 32'hCCCC_0009; in_valid = 1'b1;
        @(negedge clk);
        chk("bp_full2", {31'b0, in_ready}, 32'h0);
        step();
        rf_ready = 1'b1;
        @(negedge clk);
        chk("bp_c1_we", {31'b0, rf_we}, 32'h1);
        chk("bp_c1_addr", {27'b0, rf_waddr}, 32'd5);
        chk("bp_c1_ready", {31'b0, in_ready}, 32'h0);
        step();
        @(negedge clk);
        chk("bp_c2_addr", {27'b0, rf_waddr}, 32'd7);
        chk("bp_c2_ready", {31'b0, in_ready}, 32'h1);
        step();
        in_valid = 1'b0;
        @(negedge clk);
        chk("bp_c3_addr", {27'b0, rf_waddr}, 32'd9);
        chk("bp_c3_data", rf_wdata, 32'hCCCC_0009);
        chk("bp_hit0_clear", {31'b0, q_hit0}, 32'h0);
        step();
        @(negedge clk);
        chk("bp_retire", retire_cnt, 32'd3);
        chk("bp_empty_we", {31'b0, rf_we}, 32'h0);
        step();

        rf_ready = 1'b1;
        push(32'h400, 1'b1, 1'b0, 3'b000, 4'hF, 32'h0, 32'h0000_DEAD, 5'd0);
        @(negedge clk);
        chk("r0_we", {31'b0, rf_we}, 32'h0);
        step();
        rf_ready = 1'b0;
        push(32'h404, 1'b0, 1'b0, 3'b000, 4'hF, 32'h0, 32'h0000_BEEF, 5'd9);
        @(negedge clk);
        chk("nowr_we", {31'b0, rf_we}, 32'h0);
        chk("nowr_data", rf_wdata, 32'h0000_BEEF);
        step();
        @(negedge clk);
        chk("nowr_retire", retire_cnt, 32'd5);
        chk("nowr_empty", {31'b0, in_ready}, 32'h1);
        step();

        rf_ready = 1'b1; q_addr0 = 5'd12; q_addr1 = 5'd13;
        t0 = $time;
        push(32'h500, 1'b1, 1'b0, 3'b000, 4'hF, 32'h0, 32'h5000_0001, 5'd11);
        push(32'h504, 1'b1, 1'b1, 3'b101, 4'b0100, 32'h80F0_7F85, 32'h0, 5'd12);
        push(32'h508, 1'b1, 1'b0, 3'b000, 4'hF, 32'h0, 32'h5000_0003, 5'd13);
        push(32'h50C, 1'b1, 1'b1, 3'b000, 4'hF, 32'hCAFE_F00D, 32'h0, 5'd14);
        t1 = $time;
        chk("throughput_cycles", 32'((t1 - t0) / 10), 32'd4);
        @(negedge clk);
        chk("tp_last_data", rf_wdata, 32'hCAFE_F00D);
        step();
        @(negedge clk);
        chk("tp_retire", retire_cnt, 32'd9);
        step();

        rf_ready = 1'b0; q_addr0 = 5'd5; q_addr1 = 5'd7;
        push(32'h600, 1'b1, 1'b0, 3'b000, 4'hF, 32'h0, 32'h6000_0005, 5'd5);
        push(32'h604, 1'b1, 1'b0, 3'b000, 4'hF, 32'h0, 32'h6000_0007, 5'd7);
        @(negedge clk);
        #2 reset = 1'b0;
        #1;
        chk("mid_waddr", {27'b0, rf_waddr}, 32'h0);
        chk("mid_pc", debug_wb_pc, 32'h0);
        chk("mid_retire", retire_cnt, 32'h0);
        chk("mid_hit0", {31'b0, q_hit0}, 32'h0);
        chk("mid_ready", {31'b0, in_ready}, 32'h1);
        chk("mid_wen", {28'b0, debug_wb_rf_wen}, 32'h0);
        rf_ready = 1'b1;
        #1 reset = 1'b1;
        step();
        @(negedge clk);
        chk("post_rst_we", {31'b0, rf_we}, 32'h0);
        chk("post_rst_retire", retire_cnt, 32'h0);
        step();
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
